// File: rtl/blink_pkg.sv
// rtl/blink_pkg.sv - shared defaults and FSM state type for the blink sequencer
package blink_pkg;

   // Default build: 50 MHz board clock, 4-entry table, 3 blinks per step
   localparam int TICKS_PER_MS_DEF = 50000;
   localparam int DEPTH_DEF        = 4;
   localparam int REPEATS_DEF      = 3;
   localparam int PW_DEF           = 14;

   // Playback sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      BLINK = 2'd2,
      NEXT  = 2'd3
   } state_e;

endpackage

// File: rtl/blink_core.sv
// rtl/blink_core.sv - ms/phase/repeat counters and duty-cycle compare for one step
module blink_core
   import blink_pkg::*;
#(
   parameter int TICKS_PER_MS = TICKS_PER_MS_DEF,
   parameter int REPEATS      = REPEATS_DEF,
   parameter int PW           = PW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_i,   // clear all counters (step is being fetched)
   input  logic          en_i,      // advance counters this cycle
   input  logic [PW-1:0] p_i,       // period in ms, already forced to >= 1
   output logic          led_raw_o, // ph*4 < P, unregistered
   output logic          done_o     // last cycle of the last repeat
);

   localparam int MSW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
   localparam int RW  = (REPEATS > 1) ? $clog2(REPEATS + 1) : 1;

   logic [MSW-1:0] ms_cnt_q;
   logic [PW-1:0]  ph_q;
   logic [RW-1:0]  rep_q;

   logic ms_wrap;
   logic ph_wrap;
   logic rep_last;

   assign ms_wrap  = (ms_cnt_q == MSW'(TICKS_PER_MS - 1));
   assign ph_wrap  = (ph_q == (p_i - PW'(1)));
   assign rep_last = (rep_q == RW'(REPEATS - 1));

   // Widened by two bits so ph*4 can never overflow before the compare
   assign led_raw_o = ({ph_q, 2'b00} < {2'b00, p_i});
   assign done_o    = en_i && ms_wrap && ph_wrap && rep_last;

   // ms_cnt rolls every ms, ph every period, rep every REPEATS periods
   always_ff @(posedge clk) begin
      if (rst || start_i) begin
         ms_cnt_q <= '0;
         ph_q     <= '0;
         rep_q    <= '0;
      end else if (en_i) begin
         if (ms_wrap) begin
            ms_cnt_q <= '0;
            if (ph_wrap) begin
               ph_q  <= '0;
               rep_q <= rep_last ? '0 : rep_q + RW'(1);
            end else begin
               ph_q <= ph_q + PW'(1);
            end
         end else begin
            ms_cnt_q <= ms_cnt_q + MSW'(1);
         end
      end
   end

endmodule

// File: rtl/blink_sequencer.sv
// rtl/blink_sequencer.sv - key-programmed LED blink period sequencer
module blink_sequencer
   import blink_pkg::*;
#(
   parameter int TICKS_PER_MS = TICKS_PER_MS_DEF,
   parameter int DEPTH        = DEPTH_DEF,   // power of 2, >= 2
   parameter int REPEATS      = REPEATS_DEF,
   parameter int PW           = PW_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       key_load_n,
   input  logic                       key_run_n,
   input  logic [PW-1:0]              sw,
   output logic                       led,
   output logic                       running,
   output logic [$clog2(DEPTH)-1:0]   step_idx,
   output logic [$clog2(DEPTH):0]     n_steps
);

   localparam int IW = $clog2(DEPTH);
   localparam logic [IW:0] DEPTH_N = (IW + 1)'(DEPTH);

   // [0],[1] are the synchroniser stages, [2] is the previous synced level
   logic [2:0]      load_sync_q;
   logic [2:0]      run_sync_q;
   logic            load_p_q;
   logic            run_p_q;

   logic [PW-1:0]   table_q [DEPTH];
   logic [IW-1:0]   wr_ptr_q;
   logic [IW:0]     n_steps_q;
   logic [IW-1:0]   step_idx_q;
   logic [PW-1:0]   p_q;
   logic            running_q;
   logic            led_q;
   state_e          state_q;

   logic            table_we;
   logic [PW-1:0]   fetch_p;
   logic            core_start;
   logic            core_en;
   logic            led_raw;
   logic            core_done;

   // A simultaneous run press wins over load, so load only writes when run is quiet
   assign table_we   = (state_q == IDLE) && load_p_q && !run_p_q;
   assign fetch_p    = (table_q[step_idx_q] == '0) ? PW'(1) : table_q[step_idx_q];
   assign core_start = (state_q == FETCH);
   assign core_en    = (state_q == BLINK);

   // Synchronise both keys and turn each press (falling edge) into a 1-cycle pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         load_sync_q <= 3'b111;
         run_sync_q  <= 3'b111;
         load_p_q    <= 1'b0;
         run_p_q     <= 1'b0;
      end else begin
         load_sync_q <= {load_sync_q[1:0], key_load_n};
         run_sync_q  <= {run_sync_q[1:0], key_run_n};
         load_p_q    <= load_sync_q[2] && !load_sync_q[1];
         run_p_q     <= run_sync_q[2] && !run_sync_q[1];
      end
   end

   // Step table: plain registers, contents left as-is by reset
   always_ff @(posedge clk) begin
      if (table_we) begin
         table_q[wr_ptr_q] <= sw;
      end
   end

   blink_core #(
      .TICKS_PER_MS (TICKS_PER_MS),
      .REPEATS      (REPEATS),
      .PW           (PW)
   ) u_core (
      .clk       (clk),
      .rst       (rst),
      .start_i   (core_start),
      .en_i      (core_en),
      .p_i       (p_q),
      .led_raw_o (led_raw),
      .done_o    (core_done)
   );

   // Playback FSM with table pointers and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         running_q  <= 1'b0;
         led_q      <= 1'b0;
         step_idx_q <= '0;
         wr_ptr_q   <= '0;
         n_steps_q  <= '0;
         p_q        <= '0;
      end else begin
         // led is only driven while the counters are live in BLINK
         led_q <= running_q && (state_q == BLINK) && led_raw;

         case (state_q)
            IDLE: begin
               if (run_p_q) begin
                  if (n_steps_q != '0) begin
                     state_q    <= FETCH;
                     step_idx_q <= '0;
                     running_q  <= 1'b1;
                  end
               end else if (load_p_q) begin
                  wr_ptr_q <= wr_ptr_q + IW'(1);
                  if (n_steps_q != DEPTH_N) begin
                     n_steps_q <= n_steps_q + (IW + 1)'(1);
                  end
               end
            end
            FETCH: begin
               p_q     <= fetch_p;
               state_q <= BLINK;
            end
            BLINK: begin
               if (core_done) begin
                  state_q <= NEXT;
               end
            end
            NEXT: begin
               if (({1'b0, step_idx_q} + (IW + 1)'(1)) == n_steps_q) begin
                  step_idx_q <= '0;
               end else begin
                  step_idx_q <= step_idx_q + IW'(1);
               end
               state_q <= FETCH;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase

         // Run pressed during playback stops it; step_idx is left where it was
         if (run_p_q && (state_q != IDLE)) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            led_q     <= 1'b0;
         end
      end
   end

   assign led      = led_q;
   assign running  = running_q;
   assign step_idx = step_idx_q;
   assign n_steps  = n_steps_q;

endmodule
